// File: rtl/decode_illegal_exception_pkg.sv
// Shared types and constants for the decode-stage illegal-instruction exception block.
package decode_illegal_exception_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrain,
        StRequest,
        StFlush
    } illegal_exc_state_t;

    localparam logic [4:0] EXC_CAUSE_ILLEGAL_INST = 5'd2;
    localparam int unsigned INST_W = 32;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit increment counter that saturates at all-ones, with synchronous active-high reset.
module sat_counter32 #(
    parameter logic [31:0] ResetValue = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    output logic [31:0] count_o
);

    logic [31:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != 32'hFFFF_FFFF)) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= ResetValue;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/decode_illegal_exception.sv
// Stalls decode on an illegal instruction, waits for older work to drain, then raises a
// precise illegal-instruction exception and holds decode until the flush completes.
module decode_illegal_exception
    import decode_illegal_exception_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ID_W       = 3,
    // Reset value of illegal_count; normally zero.
    parameter logic [31:0] COUNT_INIT = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              decode_valid,
    input  logic [INST_W-1:0] decode_instruction,
    input  logic [XLEN-1:0]   decode_pc,
    input  logic [ID_W-1:0]   decode_id,
    input  logic              illegal_instruction,
    input  logic              inflight_empty,
    input  logic              gc_flush,
    output logic              decode_stall,
    output logic              exc_valid,
    input  logic              exc_ready,
    output logic [4:0]        exc_code,
    output logic [INST_W-1:0] exc_tval,
    output logic [XLEN-1:0]   exc_pc,
    output logic [ID_W-1:0]   exc_id,
    input  logic              flush_done,
    output logic [31:0]       illegal_count
);

    illegal_exc_state_t state_d, state_q;
    logic [INST_W-1:0]  tval_d, tval_q;
    logic [XLEN-1:0]    pc_d, pc_q;
    logic [ID_W-1:0]    id_d, id_q;
    logic               capture;
    logic               accept;

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (decode_valid && illegal_instruction && !gc_flush) begin
                    capture = 1'b1;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (gc_flush) begin
                    state_d = StIdle;
                end else if (inflight_empty) begin
                    state_d = StRequest;
                end
            end
            StRequest: begin
                // An accepted handshake takes priority over a same-cycle flush.
                if (exc_ready) begin
                    accept  = 1'b1;
                    state_d = StFlush;
                end else if (gc_flush) begin
                    state_d = StIdle;
                end
            end
            StFlush: begin
                if (flush_done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tval_d = tval_q;
        pc_d   = pc_q;
        id_d   = id_q;
        if (capture) begin
            tval_d = decode_instruction;
            pc_d   = decode_pc;
            id_d   = decode_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            tval_q  <= '0;
            pc_q    <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            tval_q  <= tval_d;
            pc_q    <= pc_d;
            id_q    <= id_d;
        end
    end

    sat_counter32 #(
        .ResetValue(COUNT_INIT)
    ) u_count (
        .clk_i  (clk),
        .rst_i  (rst),
        .inc_i  (accept),
        .count_o(illegal_count)
    );

    // Stall is combinational only on the capture cycle; afterwards it follows the state.
    assign decode_stall = (state_q != StIdle) || capture;
    assign exc_valid    = (state_q == StRequest);
    assign exc_code     = exc_valid ? EXC_CAUSE_ILLEGAL_INST : 5'd0;
    assign exc_tval     = tval_q;
    assign exc_pc       = pc_q;
    assign exc_id       = id_q;

endmodule

// File: tb/tb_decode_illegal_exception.sv
// Directed self-checking bench for decode_illegal_exception.
module tb_decode_illegal_exception;

    logic        clk = 1'b0;
    logic        rst;
    logic        decode_valid;
    logic [31:0] decode_instruction;
    logic [31:0] decode_pc;
    logic [2:0]  decode_id;
    logic        illegal_instruction;
    logic        inflight_empty;
    logic        gc_flush;
    logic        exc_ready;
    logic        flush_done;

    logic        decode_stall, exc_valid;
    logic [4:0]  exc_code;
    logic [31:0] exc_tval, exc_pc, illegal_count;
    logic [2:0]  exc_id;

    logic        s_decode_stall, s_exc_valid;
    logic [4:0]  s_exc_code;
    logic [31:0] s_exc_tval, s_exc_pc, s_illegal_count;
    logic [2:0]  s_exc_id;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    decode_illegal_exception dut (
        .clk                (clk),
        .rst                (rst),
        .decode_valid       (decode_valid),
        .decode_instruction (decode_instruction),
        .decode_pc          (decode_pc),
        .decode_id          (decode_id),
        .illegal_instruction(illegal_instruction),
        .inflight_empty     (inflight_empty),
        .gc_flush           (gc_flush),
        .decode_stall       (decode_stall),
        .exc_valid          (exc_valid),
        .exc_ready          (exc_ready),
        .exc_code           (exc_code),
        .exc_tval           (exc_tval),
        .exc_pc             (exc_pc),
        .exc_id             (exc_id),
        .flush_done         (flush_done),
        .illegal_count      (illegal_count)
    );

    // Second copy with the counter preloaded near saturation.
    decode_illegal_exception #(
        .COUNT_INIT(32'hFFFF_FFFE)
    ) dut_sat (
        .clk                (clk),
        .rst                (rst),
        .decode_valid       (decode_valid),
        .decode_instruction (decode_instruction),
        .decode_pc          (decode_pc),
        .decode_id          (decode_id),
        .illegal_instruction(illegal_instruction),
        .inflight_empty     (inflight_empty),
        .gc_flush           (gc_flush),
        .decode_stall       (s_decode_stall),
        .exc_valid          (s_exc_valid),
        .exc_ready          (exc_ready),
        .exc_code           (s_exc_code),
        .exc_tval           (s_exc_tval),
        .exc_pc             (s_exc_pc),
        .exc_id             (s_exc_id),
        .flush_done         (flush_done),
        .illegal_count      (s_illegal_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc, input logic [2:0] id);
        decode_valid        = 1'b1;
        illegal_instruction = 1'b1;
        decode_instruction  = instr;
        decode_pc           = pc;
        decode_id           = id;
    endtask

    task automatic quiet_decode();
        decode_valid        = 1'b0;
        illegal_instruction = 1'b0;
    endtask

    // Full exception with no drain wait and immediate acceptance.
    task automatic run_exc(input logic [31:0] instr, input logic [31:0] pc, input logic [2:0] id);
        present(instr, pc, id);
        inflight_empty = 1'b1;
        exc_ready      = 1'b1;
        tick();
        quiet_decode();
        tick();
        tick();
        exc_ready  = 1'b0;
        flush_done = 1'b1;
        tick();
        flush_done = 1'b0;
    endtask

    initial begin
        rst                 = 1'b1;
        decode_valid        = 1'b0;
        decode_instruction  = '0;
        decode_pc           = '0;
        decode_id           = '0;
        illegal_instruction = 1'b0;
        inflight_empty      = 1'b1;
        gc_flush            = 1'b0;
        exc_ready           = 1'b0;
        flush_done          = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_stall", 32'(decode_stall), 32'd0);
        chk("rst_valid", 32'(exc_valid), 32'd0);
        chk("rst_code", 32'(exc_code), 32'd0);
        chk("rst_tval", exc_tval, 32'd0);
        chk("rst_pc", exc_pc, 32'd0);
        chk("rst_id", 32'(exc_id), 32'd0);
        chk("rst_count", illegal_count, 32'd0);
        chk("rst_sat_count", s_illegal_count, 32'hFFFF_FFFE);

        // Legal stream.
        for (int i = 0; i < 10; i++) begin
            decode_valid        = 1'b1;
            illegal_instruction = 1'b0;
            decode_instruction  = 32'h0000_0013 + 32'(i);
            #1;
            chk("legal_stall", 32'(decode_stall), 32'd0);
            chk("legal_valid", 32'(exc_valid), 32'd0);
            tick();
        end
        quiet_decode();
        chk("legal_count", illegal_count, 32'd0);

        // Basic exception: capture at N, DRAIN at N+1, request at N+2.
        present(32'h0000_0000, 32'h8000_0100, 3'd3);
        inflight_empty = 1'b1;
        exc_ready      = 1'b1;
        #1;
        chk("basic_stall_comb", 32'(decode_stall), 32'd1);
        tick();
        quiet_decode();
        chk("basic_drain_valid", 32'(exc_valid), 32'd0);
        chk("basic_drain_stall", 32'(decode_stall), 32'd1);
        tick();
        chk("basic_req_valid", 32'(exc_valid), 32'd1);
        chk("basic_code", 32'(exc_code), 32'd2);
        chk("basic_tval", exc_tval, 32'h0000_0000);
        chk("basic_pc", exc_pc, 32'h8000_0100);
        chk("basic_id", 32'(exc_id), 32'd3);
        tick();
        exc_ready = 1'b0;
        chk("basic_flush_valid", 32'(exc_valid), 32'd0);
        chk("basic_count", illegal_count, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk("basic_flush_hold", 32'(decode_stall), 32'd1);
            tick();
        end
        flush_done = 1'b1;
        tick();
        flush_done = 1'b0;
        chk("basic_idle_stall", 32'(decode_stall), 32'd0);
        chk("basic_idle_code", 32'(exc_code), 32'd0);

        // Drain wait: five cycles of outstanding older work.
        present(32'hFFFF_FFFF, 32'h8000_0200, 3'd5);
        inflight_empty = 1'b0;
        tick();
        quiet_decode();
        for (int i = 0; i < 5; i++) begin
            chk("drain_stall", 32'(decode_stall), 32'd1);
            chk("drain_valid", 32'(exc_valid), 32'd0);
            tick();
        end
        inflight_empty = 1'b1;
        chk("drain_last_valid", 32'(exc_valid), 32'd0);
        tick();
        chk("drain_req_valid", 32'(exc_valid), 32'd1);
        chk("drain_tval", exc_tval, 32'hFFFF_FFFF);
        // flush_done on the cycle FLUSH is entered must be ignored.
        exc_ready  = 1'b1;
        flush_done = 1'b1;
        tick();
        exc_ready = 1'b0;
        chk("flush_early_stall", 32'(decode_stall), 32'd1);
        chk("flush_early_count", illegal_count, 32'd2);
        tick();
        flush_done = 1'b0;
        chk("flush_exit_stall", 32'(decode_stall), 32'd0);

        // Illegal instruction alongside gc_flush in IDLE is not captured.
        present(32'h0BAD_0001, 32'h8000_0250, 3'd2);
        gc_flush = 1'b1;
        #1;
        chk("idle_flush_stall", 32'(decode_stall), 32'd0);
        tick();
        quiet_decode();
        gc_flush = 1'b0;
        chk("idle_flush_state", 32'(decode_stall), 32'd0);

        // Squash in DRAIN.
        present(32'h0BAD_0002, 32'h8000_0260, 3'd4);
        inflight_empty = 1'b0;
        tick();
        quiet_decode();
        gc_flush = 1'b1;
        tick();
        gc_flush       = 1'b0;
        inflight_empty = 1'b1;
        chk("sq_drain_stall", 32'(decode_stall), 32'd0);
        tick();
        chk("sq_drain_valid", 32'(exc_valid), 32'd0);
        chk("sq_drain_count", illegal_count, 32'd2);

        // Withdrawal in REQUEST without ready.
        present(32'h1234_5678, 32'h8000_0300, 3'd1);
        tick();
        quiet_decode();
        tick();
        chk("sq_req_valid", 32'(exc_valid), 32'd1);
        gc_flush = 1'b1;
        tick();
        gc_flush = 1'b0;
        chk("sq_req_drop", 32'(exc_valid), 32'd0);
        chk("sq_req_stall", 32'(decode_stall), 32'd0);
        chk("sq_req_count", illegal_count, 32'd2);

        // gc_flush together with exc_ready: handshake wins.
        present(32'h1234_5679, 32'h8000_0304, 3'd7);
        tick();
        quiet_decode();
        tick();
        gc_flush  = 1'b1;
        exc_ready = 1'b1;
        tick();
        gc_flush  = 1'b0;
        exc_ready = 1'b0;
        chk("race_stall", 32'(decode_stall), 32'd1);
        chk("race_count", illegal_count, 32'd3);
        flush_done = 1'b1;
        tick();
        flush_done = 1'b0;

        // Backpressure with new decode traffic that must not be recaptured.
        present(32'hDEAD_BEEF, 32'h8000_0400, 3'd6);
        tick();
        present(32'hCAFE_F00D, 32'h8000_0500, 3'd2);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk("bp_valid", 32'(exc_valid), 32'd1);
            chk("bp_tval", exc_tval, 32'hDEAD_BEEF);
            chk("bp_pc", exc_pc, 32'h8000_0400);
            chk("bp_id", 32'(exc_id), 32'd6);
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        quiet_decode();
        #1;
        chk("bp_rst_stall", 32'(decode_stall), 32'd0);
        chk("bp_rst_valid", 32'(exc_valid), 32'd0);
        chk("bp_rst_code", 32'(exc_code), 32'd0);
        chk("bp_rst_tval", exc_tval, 32'd0);
        chk("bp_rst_pc", exc_pc, 32'd0);
        chk("bp_rst_id", 32'(exc_id), 32'd0);
        chk("bp_rst_count", illegal_count, 32'd0);
        tick();
        chk("bp_rst_count_hold", illegal_count, 32'd0);
        chk("bp_rst_sat_count", s_illegal_count, 32'hFFFF_FFFE);

        // Saturation on the preloaded copy.
        run_exc(32'h0000_0001, 32'h8000_0600, 3'd1);
        chk("sat_main_1", illegal_count, 32'd1);
        chk("sat_first", s_illegal_count, 32'hFFFF_FFFF);
        run_exc(32'h0000_0002, 32'h8000_0604, 3'd2);
        chk("sat_main_2", illegal_count, 32'd2);
        chk("sat_second", s_illegal_count, 32'hFFFF_FFFF);
        tick();
        chk("sat_hold", s_illegal_count, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
